// File: rtl/multi_led_blinker.sv
// multi_led_blinker: multi-channel LED driver, per-channel OFF/ON/BLINK/BURST loaded over valid/ready.
// Optional macro LED_DONE_PULSE_EN adds a done output pulsing when a burst completes naturally.
module multi_led_blinker #(
    parameter int CH_W    = 2,
    parameter int CNT_W   = 27,
    parameter int BURST_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [CNT_W-1:0]      cfg_period,
    input  logic [CNT_W-1:0]      cfg_on,
    input  logic [BURST_W-1:0]    cfg_count,
`ifdef LED_DONE_PULSE_EN
    output logic [2**CH_W-1:0]    done,
`endif
    output logic [2**CH_W-1:0]    led,
    output logic [2**CH_W-1:0]    busy
);
    localparam int NCH = 2**CH_W;

    typedef enum logic [1:0] {S_OFF, S_ON, S_RUN, S_BURST} state_t;

    logic block_q;
    logic acc;

    // ready is forced low while rst is high so a write can never coincide with reset
    assign cfg_ready = !rst && !block_q;
    assign acc       = cfg_valid && cfg_ready;

    // one dead cycle after every accepted write
    always_ff @(posedge clk) begin
        if (rst) begin
            block_q <= 1'b0;
        end else begin
            block_q <= acc;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t             st_q, st_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d, per_q, per_d, on_q, on_d;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic               led_q, led_d, busy_q, busy_d;
        logic               wr, wrap;
        logic [CNT_W-1:0]   p_eff;

        assign wr    = acc && cfg_ch == CH_W'(g);
        assign p_eff = (per_q == '0) ? CNT_W'(1) : per_q;
        assign wrap  = cnt_q == p_eff - CNT_W'(1);

        // next state: a write overrides everything, otherwise run the phase/burst counters
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            per_d  = per_q;
            on_d   = on_q;
            rem_d  = rem_q;
            led_d  = st_q == S_ON || ((st_q == S_RUN || st_q == S_BURST) && cnt_q < on_q);
            busy_d = st_q == S_BURST;
            if (wr) begin
                per_d = cfg_period;
                on_d  = cfg_on;
                rem_d = cfg_count;
                cnt_d = '0;
                st_d  = cfg_mode == 2'b00 ? S_OFF :
                        cfg_mode == 2'b01 ? S_ON  :
                        cfg_mode == 2'b10 ? S_RUN :
                        (cfg_count == '0 ? S_OFF : S_BURST);
            end else if (st_q == S_RUN || st_q == S_BURST) begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
                if (st_q == S_BURST && wrap) begin
                    rem_d = rem_q - BURST_W'(1);
                    st_d  = rem_q == BURST_W'(1) ? S_OFF : S_BURST;
                end
            end
        end

        // channel state and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= S_OFF;
                cnt_q  <= '0;
                per_q  <= '0;
                on_q   <= '0;
                rem_q  <= '0;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                per_q  <= per_d;
                on_q   <= on_d;
                rem_q  <= rem_d;
                led_q  <= led_d;
                busy_q <= busy_d;
            end
        end

        assign led[g]  = led_q;
        assign busy[g] = busy_q;

`ifdef LED_DONE_PULSE_EN
        logic fin_q, fin_d, done_q;

        assign fin_d = st_q == S_BURST && wrap && rem_q == BURST_W'(1) && !wr;

        // fin marks the completing edge; done follows one cycle later, aligned with busy falling
        always_ff @(posedge clk) begin
            if (rst) begin
                fin_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                fin_q  <= fin_d;
                done_q <= fin_q;
            end
        end

        assign done[g] = done_q;
`endif
    end
endmodule

// File: tb/tb_multi_led_blinker.sv
// tb_multi_led_blinker: directed stimulus checked every cycle against an elapsed-time model of the channels.
module tb_multi_led_blinker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [26:0] cfg_period = '0;
    logic [26:0] cfg_on = '0;
    logic [7:0]  cfg_count = '0;
    logic [3:0]  led, busy;
`ifdef LED_DONE_PULSE_EN
    logic [3:0]  done;
`endif

    multi_led_blinker dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .cfg_count  (cfg_count),
`ifdef LED_DONE_PULSE_EN
        .done       (done),
`endif
        .led        (led),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: each channel remembers its config and the edge it was accepted on;
    // outputs follow from elapsed cycles e via modular arithmetic
    int m_mode[4], m_per[4], m_on[4], m_cnt[4], m_k[4];
    int edge_n = 0;
    bit m_acc = 0;
    bit started = 0;
    logic [3:0] e_led = '0, e_busy = '0, e_done = '0;
    int p, e, ph, lim;

    always @(posedge clk) begin
        edge_n++;
        for (int c = 0; c < 4; c++) begin
            p   = m_per[c] == 0 ? 1 : m_per[c];
            e   = edge_n - 1 - m_k[c];
            ph  = e % p;
            lim = m_cnt[c] * p;
            e_led[c]  = m_mode[c] == 1 || (m_mode[c] == 2 && ph < m_on[c]) ||
                        (m_mode[c] == 3 && e < lim && ph < m_on[c]);
            e_busy[c] = m_mode[c] == 3 && e < lim;
            e_done[c] = m_mode[c] == 3 && m_cnt[c] > 0 && e == lim;
        end
        if (rst) begin
            e_led = '0;
            e_busy = '0;
            e_done = '0;
            for (int c = 0; c < 4; c++) begin
                m_mode[c] = 0;
                m_k[c] = edge_n;
            end
            m_acc = 0;
            started = 1;
        end else if (cfg_valid && !m_acc) begin
            m_mode[cfg_ch] = int'(cfg_mode);
            m_per[cfg_ch]  = int'(cfg_period);
            m_on[cfg_ch]   = int'(cfg_on);
            m_cnt[cfg_ch]  = int'(cfg_count);
            m_k[cfg_ch]    = edge_n;
            m_acc = 1;
        end else begin
            m_acc = 0;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("led", int'(led), int'(e_led));
            chk("busy", int'(busy), int'(e_busy));
            chk("cfg_ready", int'(cfg_ready), int'(!rst && !m_acc));
`ifdef LED_DONE_PULSE_EN
            chk("done", int'(done), int'(e_done));
`endif
        end
    end

    task automatic wr(input int ch, input int md, input int per, input int on, input int cnt);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(md);
        cfg_period = 27'(per);
        cfg_on     = 27'(on);
        cfg_count  = 8'(cnt);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 8);
        if (!m_acc) chk("wr_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    logic [20:0] v;
    int nb, nl, nd, a0, a1;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cfg_ready), 1);
        chk("led_after_rst", int'(led), 0);

        // BLINK ch0, period 10, on 4
        wr(0, 2, 10, 4, 0);
        v = '0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            v = {v[19:0], led[0]};
            if (i == 0) chk("ready_gap", int'(cfg_ready), 0);
            if (i == 1) chk("ready_back", int'(cfg_ready), 1);
        end
        chk("blink_wave", int'(v), int'(21'b0_1111000000_1111000000));

        // BURST ch1, period 4, on 2, count 3
        wr(1, 3, 4, 2, 3);
        nb = 0; nl = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nb += int'(busy[1]);
            nl += int'(led[1]);
`ifdef LED_DONE_PULSE_EN
            nd += int'(done[1]);
`endif
        end
        chk("burst_busy_cycles", nb, 12);
        chk("burst_led_cycles", nl, 6);
`ifdef LED_DONE_PULSE_EN
        chk("burst_done_pulses", nd, 1);
`endif

        // edge values
        wr(2, 2, 0, 1, 0);
        wr(3, 2, 5, 0, 0);
        wr(0, 2, 8, 15, 0);
        wr(1, 3, 4, 2, 0);
        repeat (12) @(negedge clk);
        chk("period0_const1", int'(led[2]), 1);
        chk("on0_const0", int'(led[3]), 0);
        chk("on_ge_p_const1", int'(led[0]), 1);
        chk("count0_busy", int'(busy[1]), 0);

        // abort a burst by reconfiguring to ON
        wr(2, 3, 4, 2, 5);
        repeat (6) @(posedge clk);
        wr(2, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_led", int'(led[2]), 1);
        chk("abort_busy", int'(busy[2]), 0);

        // back-to-back writes with valid held
        wr(0, 1, 0, 0, 0);
        a0 = edge_n;
        wr(3, 1, 0, 0, 0);
        a1 = edge_n;
        chk("b2b_spacing", a1 - a0, 2);

        // reset during a burst with a write presented
        wr(3, 3, 4, 2, 5);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = 2'd3;
        cfg_mode = 2'b01;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("rst_write_dropped", int'(led[3]), 0);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_led_blinker.md
Name: multi_led_blinker

Overview:
- Parametrised, multi-channel LED driver; successor to the single fixed-rate blinker.
- Each channel has its own mode (OFF, ON, BLINK, BURST), period and on-time, loaded at run time over a valid/ready config port.
- Sits between board LEDs and any control logic (FSMs, debug status), replacing hard-coded blink counters.

Parameters:
- CH_W, 2, channel index width; number of channels NCH = 2**CH_W.
- CNT_W, 27, width of the per-channel period/on-time counter; max period 2**CNT_W-1 cycles.
- BURST_W, 8, width of the burst repeat count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  block can accept a config write
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
- cfg_period  in  CNT_W  blink period in clk cycles
- cfg_on  in  CNT_W  cycles LED is high at start of each period
- cfg_count  in  BURST_W  number of periods for BURST
- led  out  NCH  LED outputs, active-high, registered
- busy  out  NCH  channel is running a BURST

Behaviour:
- Reset (rst=1 at a clk edge):
  - all channels go to mode OFF, counters 0, period/on/count registers 0.
  - led=0, busy=0, cfg_ready=0 during the reset cycle; cfg_ready=1 on the first cycle after rst falls.
- Handshake:
  - A write is accepted on an edge where cfg_valid && cfg_ready.
  - cfg_ready drops for exactly one cycle after each accept, then returns to 1. Back-to-back writes therefore occur at most every 2 cycles.
  - cfg_valid while cfg_ready=0 is ignored and not queued. Holding cfg_valid high works: the write is accepted when cfg_ready returns.
- Config latency:
  - A write accepted at edge k loads the channel registers and clears its phase counter at edge k.
  - led[ch] shows the new mode from edge k+1.
  - Other channels are never disturbed.
- Effective period: P = max(cfg_period, 1). Period 0 is treated as 1.
- Per-channel FSM states: S_OFF, S_ON, S_RUN, S_BURST.
  - S_OFF: led=0, busy=0.
  - S_ON: led=1, busy=0.
  - S_RUN (mode BLINK):
    - phase counter cnt steps 0..P-1, then wraps to 0 with no dead cycle.
    - led=1 when cnt < cfg_on, else 0.
    - cfg_on=0 gives constant 0; cfg_on >= P gives constant 1.
    - Runs indefinitely.
  - S_BURST (mode BURST): same waveform as S_RUN, with busy=1.
    - The remaining-period counter loads with cfg_count and decrements on each wrap (cnt==P-1).
    - On the wrap that takes it to 0: go to S_OFF, led=0 and busy=0 from the next cycle.
    - cfg_count=0: go directly to S_OFF; busy never asserts.
- Reconfiguring a channel mid-BLINK or mid-BURST aborts immediately. The counter restarts from 0; a pending burst is discarded.
- Widths:
  - Counters are unsigned CNT_W bits, compared unsigned.
  - No overflow is possible because cnt < P <= 2**CNT_W-1.
- rst asserted mid-operation overrides everything on that edge, including a simultaneous config accept.

Optional Feature:
- Macro: LED_DONE_PULSE_EN.
- Defined:
  - Adds output done  out  NCH.
  - done[ch] is a one-cycle pulse on the cycle busy[ch] falls after natural burst completion.
  - No pulse on abort by reconfig, on reset, or when cfg_count=0.
  - done resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst for 3 cycles, release -> led=0, busy=0 throughout; cfg_ready=1 on the first cycle after release.
- BLINK: write ch0 mode BLINK, period=10, on=4 -> led[0] repeats 4 cycles high, 6 low, starting the cycle after accept. Other leds stay 0. cfg_ready is 0 for exactly 1 cycle.
- BURST: ch1 BURST, period=4, on=2, count=3 -> 3 pulses of 2 cycles, busy[1]=1 for 12 cycles then 0, led[1]=0 after. With LED_DONE_PULSE_EN, done[1] pulses once in the cycle busy falls.
- Edge values:
  - period=0, on=1 gives led constant 1.
  - on=0 gives constant 0.
  - on=15, period=8 gives constant 1.
  - BURST count=0 gives busy never 1.
- Abort and overlap: ch2 BURST count=5; after 7 cycles write ch2 mode ON -> led[2]=1 from the next cycle, busy[2]=0, no done pulse. Hold cfg_valid high for 2 writes -> second accepted 2 cycles after the first.
- Reset mid-burst: assert rst during a ch3 BURST coinciding with a cfg accept -> all outputs 0 on the next cycle; the config write is discarded.
